// File: rtl/cache_pkg.sv
// Shared cache geometry: 16-bit byte address split as {tag, index, word, byte}.
// Burst FSM state encoding lives here so the top and the bench agree on it.
package cache_pkg;

   localparam int ADDR_W   = 16;
   localparam int INDEX_W  = 5;
   localparam int OFFSET_W = 5;
   localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
   localparam int WORD_W   = OFFSET_W - 2;
   localparam int WORDS    = 2 ** WORD_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DONE  = 2'd2
   } burst_state_t;

endpackage

// File: rtl/line_addr_compose.sv
// Rebuilds a byte address from {tag, index, word}; exact inverse of the address decoder.
// Purely combinational, so the word field wraps inside the line with no carry into index/tag.
module line_addr_compose
   import cache_pkg::*;
(
   input  logic [TAG_W-1:0]   tag_i,
   input  logic [INDEX_W-1:0] index_i,
   input  logic [WORD_W-1:0]  word_i,
   output logic [ADDR_W-1:0]  addr_o
);

   assign addr_o = {tag_i, index_i, word_i, 2'b00};

endmodule

// File: rtl/line_burst_addr_gen.sv
// Issues one full-line burst of WORDS beat addresses per accepted request; first beat 1 clk after accept.
// Beats hold while mem_ready is low. Define CRIT_WORD_FIRST_EN to start each burst at req_word.
module line_burst_addr_gen
   import cache_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [TAG_W-1:0]    req_tag,
   input  logic [INDEX_W-1:0]  req_index,
   input  logic [WORD_W-1:0]   req_word,
   input  logic                req_wr,
   output logic                mem_valid,
   input  logic                mem_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_wr,
   output logic                mem_last,
   output logic [WORD_W-1:0]   beat_word,
   output logic                busy,
   output logic                done
);

   localparam logic [WORD_W-1:0] LAST_CNT = WORD_W'(WORDS - 1);

   burst_state_t        state_q, state_d;
   logic [TAG_W-1:0]    tag_q, tag_d;
   logic [INDEX_W-1:0]  index_q, index_d;
   logic [WORD_W-1:0]   word_q, word_d;
   logic [WORD_W-1:0]   cnt_q, cnt_d;
   logic                wr_q, wr_d;
   logic [WORD_W-1:0]   start_word;
   logic [ADDR_W-1:0]   line_addr;

`ifdef CRIT_WORD_FIRST_EN
   assign start_word = req_word;
`else
   logic unused_req_word;
   assign unused_req_word = ^req_word;
   assign start_word      = '0;
`endif

   line_addr_compose u_compose (
      .tag_i   (tag_q),
      .index_i (index_q),
      .word_i  (word_q),
      .addr_o  (line_addr)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         tag_q   <= '0;
         index_q <= '0;
         word_q  <= '0;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
         index_q <= index_d;
         word_q  <= word_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tag_d   = tag_q;
      index_d = index_q;
      word_d  = word_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               tag_d   = req_tag;
               index_d = req_index;
               word_d  = start_word;
               wr_d    = req_wr;
               cnt_d   = '0;
               state_d = BURST;
            end
         end
         BURST: begin
            // word and count are both WORD_W wide, so +1 wraps modulo WORDS
            if (mem_ready) begin
               word_d = word_q + 1'b1;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == LAST_CNT) begin
                  state_d = DONE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready = 1'b0;
      mem_valid = 1'b0;
      mem_addr  = '0;
      mem_wr    = 1'b0;
      mem_last  = 1'b0;
      beat_word = '0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state_q)
         IDLE: req_ready = 1'b1;
         BURST: begin
            mem_valid = 1'b1;
            mem_addr  = line_addr;
            mem_wr    = wr_q;
            mem_last  = (cnt_q == LAST_CNT);
            beat_word = word_q;
            busy      = 1'b1;
         end
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_line_burst_addr_gen.sv
// Directed bench for line_burst_addr_gen: inputs driven and outputs sampled on the falling edge.
module tb_line_burst_addr_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [5:0]  req_tag;
   logic [4:0]  req_index;
   logic [2:0]  req_word;
   logic        req_wr;
   logic        mem_valid;
   logic        mem_ready;
   logic [15:0] mem_addr;
   logic        mem_wr;
   logic        mem_last;
   logic [2:0]  beat_word;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   line_burst_addr_gen dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_tag   (req_tag),
      .req_index (req_index),
      .req_word  (req_word),
      .req_wr    (req_wr),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_wr    (mem_wr),
      .mem_last  (mem_last),
      .beat_word (beat_word),
      .busy      (busy),
      .done      (done)
   );

   task automatic issue(input logic [5:0] t, input logic [4:0] x, input logic [2:0] w, input logic wr);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL issue_ready: req_ready=%b expected 1", req_ready);
      end
      req_valid = 1'b1;
      req_tag   = t;
      req_index = x;
      req_word  = w;
      req_wr    = wr;
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if (mem_valid !== 1'b1) begin
         errors++;
         $display("FAIL first_beat_latency: mem_valid=%b expected 1", mem_valid);
      end
   endtask

   // Checks each presented beat against base + 4*word, accepting stop_after beats.
   task automatic check_beats(input logic [15:0] base, input logic [2:0] w, input logic wr,
                              input bit stall, input int stop_after);
      logic [2:0]  eff;
      logic [2:0]  exp_word;
      logic [15:0] exp_addr;
      int n   = 0;
      int cyc = 0;
`ifdef CRIT_WORD_FIRST_EN
      eff = w;
`else
      eff = 3'd0;
`endif
      while (n < stop_after && cyc < 40) begin
         exp_word = eff + 3'(n);
         exp_addr = base + 16'(exp_word) * 16'd4;
         checks++;
         if (mem_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL beat_ctrl n=%0d: valid=%b busy=%b done=%b rdy=%b expected 1 1 0 0",
                     n, mem_valid, busy, done, req_ready);
         end
         checks++;
         if (mem_addr !== exp_addr) begin
            errors++;
            $display("FAIL beat_addr n=%0d: mem_addr=%h expected %h", n, mem_addr, exp_addr);
         end
         checks++;
         if (beat_word !== exp_word) begin
            errors++;
            $display("FAIL beat_word n=%0d: beat_word=%0d expected %0d", n, beat_word, exp_word);
         end
         checks++;
         if (mem_last !== (n == 7)) begin
            errors++;
            $display("FAIL beat_last n=%0d: mem_last=%b expected %b", n, mem_last, (n == 7));
         end
         checks++;
         if (mem_wr !== wr) begin
            errors++;
            $display("FAIL beat_wr n=%0d: mem_wr=%b expected %b", n, mem_wr, wr);
         end
         mem_ready = stall ? ((cyc % 2) == 0) : 1'b1;
         if (mem_ready) n++;
         cyc++;
         @(negedge clk);
      end
      mem_ready = 1'b0;
      checks++;
      if (n != stop_after) begin
         errors++;
         $display("FAIL beat_count: accepted=%0d expected %0d within cycle budget", n, stop_after);
      end
   endtask

   task automatic check_tail();
      checks++;
      if (done !== 1'b1 || mem_valid !== 1'b0 || req_ready !== 1'b0 || busy !== 1'b1 || mem_last !== 1'b0) begin
         errors++;
         $display("FAIL done_cycle: done=%b valid=%b rdy=%b busy=%b last=%b expected 1 0 0 1 0",
                  done, mem_valid, req_ready, busy, mem_last);
      end
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL back_to_idle: rdy=%b done=%b busy=%b expected 1 0 0", req_ready, done, busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 1'b0;
      req_tag = '0;
      req_index = '0;
      req_word = '0;
      req_wr = 1'b0;
      mem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || mem_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: rdy=%b valid=%b busy=%b done=%b expected 1 0 0 0",
                  req_ready, mem_valid, busy, done);
      end
      checks++;
      if (mem_addr !== 16'h0000 || beat_word !== 3'd0 || mem_wr !== 1'b0 || mem_last !== 1'b0) begin
         errors++;
         $display("FAIL reset_data: addr=%h word=%0d wr=%b last=%b expected 0000 0 0 0",
                  mem_addr, beat_word, mem_wr, mem_last);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_refill();
      issue(6'h2A, 5'h13, 3'd0, 1'b0);
      check_beats(16'hAA60, 3'd0, 1'b0, 1'b0, 8);
      check_tail();
   endtask

   task automatic test_crit_word();
      issue(6'h2A, 5'h13, 3'd5, 1'b0);
      check_beats(16'hAA60, 3'd5, 1'b0, 1'b0, 8);
      check_tail();
   endtask

   task automatic test_writeback_stall();
      issue(6'h2A, 5'h13, 3'd0, 1'b1);
      check_beats(16'hAA60, 3'd0, 1'b1, 1'b1, 8);
      check_tail();
   endtask

   task automatic test_reset_mid_burst();
      issue(6'h2A, 5'h13, 3'd0, 1'b0);
      check_beats(16'hAA60, 3'd0, 1'b0, 1'b0, 3);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || mem_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
          mem_addr !== 16'h0000 || beat_word !== 3'd0 || mem_wr !== 1'b0 || mem_last !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: rdy=%b valid=%b busy=%b done=%b addr=%h word=%0d wr=%b last=%b expected reset values",
                  req_ready, mem_valid, busy, done, mem_addr, beat_word, mem_wr, mem_last);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_nodone: done=%b rdy=%b expected 0 1", done, req_ready);
      end
      issue(6'h05, 5'h02, 3'd2, 1'b0);
      check_beats(16'h1440, 3'd2, 1'b0, 1'b0, 8);
      check_tail();
   endtask

   task automatic test_back_to_back();
      issue(6'h2A, 5'h13, 3'd0, 1'b0);
      req_valid = 1'b1;
      req_tag   = 6'h05;
      req_index = 5'h02;
      req_word  = 3'd3;
      req_wr    = 1'b1;
      check_beats(16'hAA60, 3'd0, 1'b0, 1'b0, 8);
      check_tail();
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if (mem_valid !== 1'b1) begin
         errors++;
         $display("FAIL held_req_accept: mem_valid=%b expected 1", mem_valid);
      end
      check_beats(16'h1440, 3'd3, 1'b1, 1'b0, 8);
      check_tail();
   endtask

   task automatic test_boundary();
      issue(6'h3F, 5'h1F, 3'd0, 1'b0);
      check_beats(16'hFFE0, 3'd0, 1'b0, 1'b0, 8);
      check_tail();
   endtask

   initial begin
      test_reset();
      test_refill();
      test_crit_word();
      test_writeback_stall();
      test_reset_mid_burst();
      test_back_to_back();
      test_boundary();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
